dma_controller: RTL and testbench

DMA_CONTROLLER -- requirements
Module: dma_controller

---
 rtl/dma_controller.sv | 259 +++++++++++++++++++++++++
 tb/tb_dma_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller.sv
`default_nettype none
// ============================================================================
//  Module      : dma_controller
//  Description : Descriptor-driven single-channel DMA engine. It fetches a
//                four-word descriptor from internal memory at desc_base and
//                then copies 'count' words one at a time between the
//                internal (np) and external (sp) memory ports.
//                The descriptor words are: w0 = internal address,
//                w1 = external address, w2 = word count and w3 = control.
//                In the control word, bit0 = DIR (0: int->ext, 1: ext->int)
//                and bit1 = CHAIN.
//
//  Ports       : clk        - single clock, rising-edge active
//                rst        - synchronous active-high reset
//                stall_int  - holds any state that drives the internal port
//                stall_ext  - holds any state that drives the external port
//                reg_access - host register access in progress (IDLE only)
//                NPD_IN     - internal read data, valid one cycle after read
//                SPD_IN     - external read data, valid one cycle after read
//                np_en/sp_en, wr_rd_np/wr_rd_sp (1 = write, 0 = read)
//                NPA/SPA    - port addresses
//                NPD_OUT/SPD_OUT - port write data (always the buffer)
//
//  Options     : DMAC_DESC_CHAIN_EN - when defined, a transfer whose control
//                word has CHAIN=1 fetches the next descriptor at
//                desc_base+4 instead of stopping in DONE.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_controller #(
    parameter int ADR_SIZE  = 16,
    parameter int DATA_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_int,
    input  logic                 stall_ext,
    input  logic                 reg_access,
    input  logic [DATA_SIZE-1:0] NPD_IN,
    input  logic [DATA_SIZE-1:0] SPD_IN,
    output logic                 wr_rd_np,
    output logic                 wr_rd_sp,
    output logic                 np_en,
    output logic                 sp_en,
    output logic [ADR_SIZE-1:0]  NPA,
    output logic [ADR_SIZE-1:0]  SPA,
    output logic [DATA_SIZE-1:0] NPD_OUT,
    output logic [DATA_SIZE-1:0] SPD_OUT
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DREAD  = 3'd1;
    localparam logic [2:0] S_DCAP   = 3'd2;
    localparam logic [2:0] S_XREAD  = 3'd3;
    localparam logic [2:0] S_XCAP   = 3'd4;
    localparam logic [2:0] S_XWRITE = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [ADR_SIZE-1:0] c_adr_one   = ADR_SIZE'(1);
    localparam logic [ADR_SIZE-1:0] c_desc_step = ADR_SIZE'(4);

`ifdef DMAC_DESC_CHAIN_EN
    localparam bit c_chain_en = 1'b1;
`else
    localparam bit c_chain_en = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [1:0]           r_k;
    logic [ADR_SIZE-1:0]  r_desc_base;
    logic [ADR_SIZE-1:0]  r_int_addr;
    logic [ADR_SIZE-1:0]  r_ext_addr;
    logic [ADR_SIZE-1:0]  r_count;
    logic                 r_dir;
    logic                 r_chain;
    logic [DATA_SIZE-1:0] r_buf;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [ADR_SIZE-1:0] w_npd_adr;
    logic [ADR_SIZE-1:0] w_desc_adr;
    logic [ADR_SIZE-1:0] w_count_dec;
    logic                w_drive_int;
    logic                w_drive_ext;
    logic                w_hold;

    // Descriptor words arrive on the data bus but are stored as addresses /
    // counts, so adapt the data width to the address width.
    generate
        if (DATA_SIZE >= ADR_SIZE) begin : g_npd_trunc
            assign w_npd_adr = NPD_IN[ADR_SIZE-1:0];
        end else begin : g_npd_zext
            assign w_npd_adr = {{(ADR_SIZE-DATA_SIZE){1'b0}}, NPD_IN};
        end
    endgenerate

    assign w_desc_adr  = r_desc_base + ADR_SIZE'(r_k);
    assign w_count_dec = r_count - c_adr_one;

    // Which port the current state uses; a stall only matters for that port.
    assign w_drive_int = (r_state == S_DREAD)
                       | ((r_state == S_XREAD)  & ~r_dir)
                       | ((r_state == S_XWRITE) &  r_dir);
    assign w_drive_ext = ((r_state == S_XREAD)  &  r_dir)
                       | ((r_state == S_XWRITE) & ~r_dir);
    assign w_hold      = (w_drive_int & stall_int) | (w_drive_ext & stall_ext);

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= 2'd0;
            r_desc_base <= '0;
            r_int_addr  <= '0;
            r_ext_addr  <= '0;
            r_count     <= '0;
            r_dir       <= 1'b0;
            r_chain     <= 1'b0;
            r_buf       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!reg_access) begin
                        r_state     <= S_DREAD;
                        r_k         <= 2'd0;
                        r_desc_base <= '0;
                    end
                end

                S_DREAD: begin
                    if (!w_hold) begin
                        r_state <= S_DCAP;
                    end
                end

                S_DCAP: begin
                    if (r_k == 2'd0) begin
                        r_int_addr <= w_npd_adr;
                    end else if (r_k == 2'd1) begin
                        r_ext_addr <= w_npd_adr;
                    end else if (r_k == 2'd2) begin
                        r_count <= w_npd_adr;
                    end else begin
                        r_dir   <= NPD_IN[0];
                        r_chain <= NPD_IN[1];
                    end

                    if (r_k != 2'd3) begin
                        r_k     <= r_k + 2'd1;
                        r_state <= S_DREAD;
                    end else if (r_count != '0) begin
                        r_state <= S_XREAD;
                    end else if (c_chain_en && NPD_IN[1]) begin
                        // Zero-length descriptor that still chains onward;
                        // CHAIN comes straight off the bus as it is latched now.
                        r_desc_base <= r_desc_base + c_desc_step;
                        r_k         <= 2'd0;
                        r_state     <= S_DREAD;
                    end else begin
                        r_state <= S_DONE;
                    end
                end

                S_XREAD: begin
                    if (!w_hold) begin
                        r_state <= S_XCAP;
                    end
                end

                S_XCAP: begin
                    r_buf   <= r_dir ? SPD_IN : NPD_IN;
                    r_state <= S_XWRITE;
                end

                S_XWRITE: begin
                    if (!w_hold) begin
                        r_int_addr <= r_int_addr + c_adr_one;
                        r_ext_addr <= r_ext_addr + c_adr_one;
                        r_count    <= w_count_dec;
                        if (w_count_dec != '0) begin
                            r_state <= S_XREAD;
                        end else if (c_chain_en && r_chain) begin
                            r_desc_base <= r_desc_base + c_desc_step;
                            r_k         <= 2'd0;
                            r_state     <= S_DREAD;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_DONE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode: state/register based, with the active port's enable
    // masked by its stall, and everything forced low while rst is asserted.
    // ------------------------------------------------------------------------
    always_comb begin
        np_en    = 1'b0;
        sp_en    = 1'b0;
        wr_rd_np = 1'b0;
        wr_rd_sp = 1'b0;
        NPA      = '0;
        SPA      = '0;
        NPD_OUT  = '0;
        SPD_OUT  = '0;
        if (!rst) begin
            NPA     = r_int_addr;
            SPA     = r_ext_addr;
            NPD_OUT = r_buf;
            SPD_OUT = r_buf;
            case (r_state)
                S_DREAD: begin
                    np_en = ~stall_int;
                    NPA   = w_desc_adr;
                end
                S_XREAD: begin
                    if (r_dir) begin
                        sp_en = ~stall_ext;
                    end else begin
                        np_en = ~stall_int;
                    end
                end
                S_XWRITE: begin
                    if (r_dir) begin
                        np_en    = ~stall_int;
                        wr_rd_np = 1'b1;
                    end else begin
                        sp_en    = ~stall_ext;
                        wr_rd_sp = 1'b1;
                    end
                end
                default: begin
                    np_en = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_controller
//  Description : Self-checking bench for dma_controller. Behavioural memory
//                models sit on both ports; every expected write (port,
//                address, data, cycle) is queued when a test is set up and
//                compared when the DUT issues the write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_controller;

    localparam int ADR_SIZE  = 16;
    localparam int DATA_SIZE = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 stall_int = 1'b0;
    logic                 stall_ext = 1'b0;
    logic                 reg_access = 1'b0;
    logic [DATA_SIZE-1:0] NPD_IN = '0;
    logic [DATA_SIZE-1:0] SPD_IN = '0;
    logic                 wr_rd_np, wr_rd_sp, np_en, sp_en;
    logic [ADR_SIZE-1:0]  NPA, SPA;
    logic [DATA_SIZE-1:0] NPD_OUT, SPD_OUT;

    always #5 clk = ~clk;

    dma_controller #(.ADR_SIZE(ADR_SIZE), .DATA_SIZE(DATA_SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_int  (stall_int),
        .stall_ext  (stall_ext),
        .reg_access (reg_access),
        .NPD_IN     (NPD_IN),
        .SPD_IN     (SPD_IN),
        .wr_rd_np   (wr_rd_np),
        .wr_rd_sp   (wr_rd_sp),
        .np_en      (np_en),
        .sp_en      (sp_en),
        .NPA        (NPA),
        .SPA        (SPA),
        .NPD_OUT    (NPD_OUT),
        .SPD_OUT    (SPD_OUT)
    );

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ------------------------------------------------------------------------
    // Memory models: init contents written by the stimulus process, DUT
    // writes kept separately by the model process.
    // ------------------------------------------------------------------------
    logic [15:0] int_init [int];
    logic [15:0] ext_init [int];
    logic [15:0] int_wr   [int];
    logic [15:0] ext_wr   [int];
    logic        clr_mem = 1'b0;

    function automatic logic [15:0] int_rd(input int a);
        if (int_wr.exists(a))   return int_wr[a];
        if (int_init.exists(a)) return int_init[a];
        return 16'h0;
    endfunction

    function automatic logic [15:0] ext_rd(input int a);
        if (ext_wr.exists(a))   return ext_wr[a];
        if (ext_init.exists(a)) return ext_init[a];
        return 16'h0;
    endfunction

    always @(posedge clk) begin
        if (clr_mem) begin
            int_wr.delete();
            ext_wr.delete();
        end else begin
            if (np_en) begin
                if (wr_rd_np) int_wr[int'(NPA)] = NPD_OUT;
                else          NPD_IN <= int_rd(int'(NPA));
            end
            if (sp_en) begin
                if (wr_rd_sp) ext_wr[int'(SPA)] = SPD_OUT;
                else          SPD_IN <= ext_rd(int'(SPA));
            end
        end
    end

    // Cycle index: number of rising edges since the last reset edge.
    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // ------------------------------------------------------------------------
    // Scoreboard and monitor
    // ------------------------------------------------------------------------
    typedef struct {
        bit          port;   // 1 = external, 0 = internal
        logic [15:0] adr;
        logic [15:0] dat;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    bit  mon_en = 1'b0;
    int  n_np_rd = 0;
    int  n_sp_rd = 0;

    task automatic expect_wr(input bit port, input logic [15:0] adr, input logic [15:0] dat, input int c);
        wr_t e;
        e.port = port; e.adr = adr; e.dat = dat; e.cyc = c;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (np_en && !wr_rd_np) n_np_rd++;
            if (sp_en && !wr_rd_sp) n_sp_rd++;
            if (stall_ext) check("sp_en_while_stalled", 64'(sp_en), 64'(0));
            if (stall_int) check("np_en_while_stalled", 64'(np_en), 64'(0));
            if ((np_en && wr_rd_np) || (sp_en && wr_rd_sp)) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write", 64'({np_en, sp_en}), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_port", 64'(sp_en), 64'(mon_e.port));
                    check("wr_adr",  64'(sp_en ? SPA : NPA), 64'(mon_e.adr));
                    check("wr_dat",  64'(sp_en ? SPD_OUT : NPD_OUT), 64'(mon_e.dat));
                    check("wr_cyc",  64'(cyc), 64'(mon_e.cyc));
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers; input windows are expressed in cycle indices.
    // ------------------------------------------------------------------------
    int si_lo = 0, si_hi = 0, se_lo = 0, se_hi = 0, ra_lo = 0, ra_hi = 0;

    task automatic drive();
        stall_int  = (cyc >= si_lo) && (cyc < si_hi);
        stall_ext  = (cyc >= se_lo) && (cyc < se_hi);
        reg_access = (cyc >= ra_lo) && (cyc < ra_hi);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            drive();
        end
    endtask

    task automatic clear_windows();
        si_lo = 0; si_hi = 0; se_lo = 0; se_hi = 0; ra_lo = 0; ra_hi = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, 64'({np_en, sp_en, wr_rd_np, wr_rd_sp}), 64'(0));
        check({tag, "_adr"}, 64'({NPA, SPA}), 64'(0));
        check({tag, "_dat"}, 64'({NPD_OUT, SPD_OUT}), 64'(0));
    endtask

    // Assert reset for one edge, wiping memories and the scoreboard.
    task automatic begin_reset();
        rst = 1'b1; mon_en = 1'b0; clr_mem = 1'b1;
        clear_windows();
        @(posedge clk); #1;
        drive();
        clr_mem = 1'b0;
        int_init.delete();
        ext_init.delete();
        exp_q.delete();
    endtask

    task automatic end_reset();
        @(negedge clk);
        check_outputs_zero("in_reset");
        @(posedge clk); #1;
        rst = 1'b0; mon_en = 1'b1; n_np_rd = 0; n_sp_rd = 0;
        drive();
    endtask

    task automatic set_desc(input int base, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
        int_init[base]     = w0;
        int_init[base + 1] = w1;
        int_init[base + 2] = w2;
        int_init[base + 3] = w3;
    endtask

    task automatic end_test(input string tag, input int exp_np_rd, input int exp_sp_rd);
        check({tag, "_np_reads"}, 64'(n_np_rd), 64'(exp_np_rd));
        check({tag, "_sp_reads"}, 64'(n_sp_rd), 64'(exp_sp_rd));
        check({tag, "_pending"},  64'(exp_q.size()), 64'(0));
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    initial begin
        // A: 3-word internal->external copy; reg_access toggled mid-transfer.
        begin_reset();
        set_desc(0, 16'h0010, 16'h0100, 16'd3, 16'h0000);
        int_init[16'h10] = 16'h00A1; int_init[16'h11] = 16'h00A2; int_init[16'h12] = 16'h00A3;
        expect_wr(1'b1, 16'h0100, 16'h00A1, 11);
        expect_wr(1'b1, 16'h0101, 16'h00A2, 14);
        expect_wr(1'b1, 16'h0102, 16'h00A3, 17);
        ra_lo = 3; ra_hi = 16;
        end_reset();
        step(25);
        end_test("A", 7, 0);
        check("A_ext_mem_last", 64'(ext_rd(16'h102)), 64'(16'h00A3));

        // B: 2-word external->internal copy, held 2 cycles in IDLE by
        // reg_access; stalls on the unused port must not matter.
        begin_reset();
        set_desc(0, 16'h0020, 16'h0200, 16'd2, 16'h0001);
        ext_init[16'h200] = 16'h5A5A; ext_init[16'h201] = 16'h1234;
        expect_wr(1'b0, 16'h0020, 16'h5A5A, 13);
        expect_wr(1'b0, 16'h0021, 16'h1234, 16);
        ra_lo = 0; ra_hi = 2; se_lo = 1; se_hi = 11; si_lo = 11; si_hi = 13;
        end_reset();
        step(25);
        end_test("B", 4, 2);
        check("B_int_mem_last", 64'(int_rd(16'h21)), 64'(16'h1234));

        // C: zero word count -> no transfer accesses at all.
        begin_reset();
        set_desc(0, 16'h0030, 16'h0300, 16'd0, 16'h0000);
        int_init[16'h30] = 16'h7777; ext_init[16'h300] = 16'hBEEF;
        end_reset();
        step(20);
        end_test("C", 4, 0);
        check("C_ext_untouched", 64'(ext_rd(16'h300)), 64'(16'hBEEF));

        // D: stall_int 2 cycles on word 0's read, stall_ext 3 cycles on
        // word 1's write.
        begin_reset();
        set_desc(0, 16'h0040, 16'h0140, 16'd3, 16'h0000);
        int_init[16'h40] = 16'h1111; int_init[16'h41] = 16'h2222; int_init[16'h42] = 16'h3333;
        expect_wr(1'b1, 16'h0140, 16'h1111, 13);
        expect_wr(1'b1, 16'h0141, 16'h2222, 19);
        expect_wr(1'b1, 16'h0142, 16'h3333, 22);
        si_lo = 9; si_hi = 11; se_lo = 16; se_hi = 19;
        end_reset();
        step(30);
        end_test("D", 7, 0);
        check("D_ext_mem_mid", 64'(ext_rd(16'h141)), 64'(16'h2222));

        // E: reset pulsed during word 1's XCAP of a 3-word copy; reg_access
        // then keeps the controller parked in IDLE.
        begin_reset();
        set_desc(0, 16'h0010, 16'h0100, 16'd3, 16'h0000);
        int_init[16'h10] = 16'h00A1; int_init[16'h11] = 16'h00A2; int_init[16'h12] = 16'h00A3;
        ext_init[16'h101] = 16'hDEAD; ext_init[16'h102] = 16'hDEAD;
        expect_wr(1'b1, 16'h0100, 16'h00A1, 11);
        end_reset();
        step(13);
        rst = 1'b1;
        #1;
        check_outputs_zero("E_rst_asserted");
        ra_lo = 0; ra_hi = 1000;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("E_after_rst");
        step(15);
        end_test("E", 6, 0);
        check("E_ext_word0", 64'(ext_rd(16'h100)), 64'(16'h00A1));
        check("E_ext_word1", 64'(ext_rd(16'h101)), 64'(16'hDEAD));

        // F: descriptor chaining (CHAIN=1 on descriptor 0).
        begin_reset();
        set_desc(0, 16'h0050, 16'h0150, 16'd2, 16'h0002);
        set_desc(4, 16'h0060, 16'h0160, 16'd1, 16'h0000);
        int_init[16'h50] = 16'hC001; int_init[16'h51] = 16'hC002; int_init[16'h60] = 16'hC003;
        expect_wr(1'b1, 16'h0150, 16'hC001, 11);
        expect_wr(1'b1, 16'h0151, 16'hC002, 14);
`ifdef DMAC_DESC_CHAIN_EN
        expect_wr(1'b1, 16'h0160, 16'hC003, 25);
`endif
        end_reset();
        step(35);
`ifdef DMAC_DESC_CHAIN_EN
        end_test("F", 11, 0);
        check("F_ext_chained", 64'(ext_rd(16'h160)), 64'(16'hC003));
`else
        end_test("F", 6, 0);
        check("F_ext_chained", 64'(ext_rd(16'h160)), 64'(16'h0000));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
